// File: rtl/regfile_2r1w_sb_if.sv
// Port bundle for regfile_2r1w_sb: write, dual read and scoreboard signals.
interface regfile_2r1w_sb_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  localparam int NREG = 1 << AW;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [AW-1:0]   rd_addr_a;
  logic [DW-1:0]   rd_data_a;
  logic [AW-1:0]   rd_addr_b;
  logic [DW-1:0]   rd_data_b;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            busy_a;
  logic            busy_b;
  logic [NREG-1:0] pend_vec;
  logic            rsv_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, pend_vec, rsv_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, pend_vec, rsv_err
  );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with per-register pending-write scoreboard.
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w_sb #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input logic             clk,
  input logic             rst_n,
  regfile_2r1w_sb_if.slave bus
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         pend;
  logic                    err;

  // Reserve is applied after the write clear so set wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
      pend <= '0;
      err  <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        regs[bus.wr_addr] <= bus.wr_data;
        pend[bus.wr_addr] <= 1'b0;
      end
      if (bus.rsv_en) begin
        pend[bus.rsv_addr] <= 1'b1;
        if (pend[bus.rsv_addr] && !(bus.wr_en && bus.wr_addr == bus.rsv_addr))
          err <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;

  always_comb begin
    fwd_a = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
    fwd_b = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr_b);
    bus.rd_data_a = fwd_a ? bus.wr_data : regs[bus.rd_addr_a];
    bus.rd_data_b = fwd_b ? bus.wr_data : regs[bus.rd_addr_b];
    // A forwarded value is only busy again if it is re-reserved this same cycle.
    bus.busy_a = fwd_a ? (bus.rsv_en && bus.rsv_addr == bus.rd_addr_a) : pend[bus.rd_addr_a];
    bus.busy_b = fwd_b ? (bus.rsv_en && bus.rsv_addr == bus.rd_addr_b) : pend[bus.rd_addr_b];
  end
`else
  always_comb begin
    bus.rd_data_a = regs[bus.rd_addr_a];
    bus.rd_data_b = regs[bus.rd_addr_b];
    bus.busy_a    = pend[bus.rd_addr_a];
    bus.busy_b    = pend[bus.rd_addr_b];
  end
`endif

  assign bus.pend_vec = pend;
  assign bus.rsv_err  = err;
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: directed literal checks plus a randomized run
// compared every cycle against an array-based reference model.
module tb_regfile_2r1w_sb;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regfile_2r1w_sb_if #(.DW(DW), .AW(AW)) bus ();

  regfile_2r1w_sb #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] mreg [NREG];
  bit            mpend [NREG];
  bit            merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays updated from the rules at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mreg[i] = '0;
        mpend[i] = 1'b0;
      end
      merr = 1'b0;
    end else begin
      if (bus.rsv_en && mpend[bus.rsv_addr] && !(bus.wr_en && bus.wr_addr == bus.rsv_addr))
        merr = 1'b1;
      if (bus.wr_en) begin
        mreg[bus.wr_addr] = bus.wr_data;
        mpend[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_en) mpend[bus.rsv_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (BYP && rst_n && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (BYP && rst_n && bus.wr_en && bus.wr_addr == a) return bus.rsv_en && bus.rsv_addr == a;
    return mpend[a];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      logic [NREG-1:0] pv;
      for (int i = 0; i < NREG; i++) pv[i] = mpend[i];
      chk("cyc_rd_a", 32'(bus.rd_data_a), 32'(exp_rd(bus.rd_addr_a)));
      chk("cyc_rd_b", 32'(bus.rd_data_b), 32'(exp_rd(bus.rd_addr_b)));
      chk("cyc_busy_a", 32'(bus.busy_a), 32'(exp_busy(bus.rd_addr_a)));
      chk("cyc_busy_b", 32'(bus.busy_b), 32'(exp_busy(bus.rd_addr_b)));
      chk("cyc_pend", 32'(bus.pend_vec), 32'(pv));
      chk("cyc_err", 32'(bus.rsv_err), 32'(merr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic rsv(input int a);
    bus.rsv_en = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  initial begin
    idle();
    bus.wr_addr = '0; bus.wr_data = '0; bus.rsv_addr = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset after random writes and reservations
    for (int i = 0; i < 6; i++) begin
      wr($urandom_range(0, 7), 16'($urandom));
      rsv($urandom_range(0, 7));
      cyc();
    end
    rst_n = 1'b0;
    wr(4, 16'h7777); rsv(4);
    cyc();
    rst_n = 1'b1; idle();
    for (int i = 0; i < NREG; i++) begin
      bus.rd_addr_a = AW'(i); bus.rd_addr_b = AW'(NREG - 1 - i);
      #1;
      chk("rst_rd_a", 32'(bus.rd_data_a), 32'h0);
      chk("rst_rd_b", 32'(bus.rd_data_b), 32'h0);
    end
    chk("rst_pend", 32'(bus.pend_vec), 32'h00);
    chk("rst_err", 32'(bus.rsv_err), 32'h0);

    // Dual read
    wr(3, 16'hABCD); cyc();
    wr(5, 16'h1234); cyc();
    idle();
    bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd5; #1;
    chk("dual_a", 32'(bus.rd_data_a), 32'hABCD);
    chk("dual_b", 32'(bus.rd_data_b), 32'h1234);
    bus.rd_addr_a = 3'd5; #1;
    chk("same_a", 32'(bus.rd_data_a), 32'h1234);
    chk("same_b", 32'(bus.rd_data_b), 32'h1234);

    // Scoreboard set then retire
    rsv(2); cyc();
    idle(); bus.rd_addr_a = 3'd2; #1;
    chk("sb_pend", 32'(bus.pend_vec), 32'h04);
    chk("sb_busy", 32'(bus.busy_a), 32'h1);
    cyc();
    wr(2, 16'h00FF); cyc();
    idle(); #1;
    chk("sb_clr_pend", 32'(bus.pend_vec), 32'h00);
    chk("sb_clr_busy", 32'(bus.busy_a), 32'h0);
    chk("sb_clr_rd", 32'(bus.rd_data_a), 32'h00FF);

    // Collision: reserve+write same register, then a true double reserve
    rsv(6); cyc();
    rsv(6); wr(6, 16'h5555); cyc();
    idle(); bus.rd_addr_a = 3'd6; #1;
    chk("col_rd", 32'(bus.rd_data_a), 32'h5555);
    chk("col_pend6", 32'(bus.pend_vec[6]), 32'h1);
    chk("col_err0", 32'(bus.rsv_err), 32'h0);
    rsv(6); cyc();
    idle(); #1;
    chk("col_err1", 32'(bus.rsv_err), 32'h1);
    repeat (10) cyc();
    chk("col_err_held", 32'(bus.rsv_err), 32'h1);
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; #1;
    chk("col_err_rst", 32'(bus.rsv_err), 32'h0);

    // Bypass visibility before and after the edge
    bus.rd_addr_a = 3'd1;
    wr(1, 16'hBEEF); #1;
    chk("byp_pre", 32'(bus.rd_data_a), BYP ? 32'hBEEF : 32'h0000);
    cyc();
    idle(); #1;
    chk("byp_post", 32'(bus.rd_data_a), 32'hBEEF);

    // Reset mid-operation discards reservations and the colliding write
    rsv(0); cyc();
    rsv(7); cyc();
    idle();
    rst_n = 1'b0; wr(7, 16'hFFFF); cyc();
    rst_n = 1'b1; idle(); bus.rd_addr_a = 3'd7; #1;
    chk("mid_rd7", 32'(bus.rd_data_a), 32'h0000);
    chk("mid_pend", 32'(bus.pend_vec), 32'h00);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.wr_en = $urandom_range(0, 1);
      bus.wr_addr = AW'($urandom);
      bus.wr_data = 16'($urandom);
      bus.rsv_en = ($urandom_range(0, 3) == 0);
      bus.rsv_addr = ($urandom_range(0, 2) == 0) ? bus.wr_addr : AW'($urandom);
      bus.rd_addr_a = ($urandom_range(0, 2) == 0) ? bus.wr_addr : AW'($urandom);
      bus.rd_addr_b = AW'($urandom);
      cyc();
    end
    rst_n = 1'b1; idle();
    cyc();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
